// File: rtl/computer.sv
// Minimal 8-bit accumulator computer: 16-word RAM, A/B registers, flags and a five-state (T0-T4) control unit.
// Define OUT_TRACE_EN to print every new out_val from the OUT instruction.

module data_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] latched_data
);
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            latched_data <= '0;
        else if (load)
            latched_data <= d;
    end
endmodule

module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // NOTE: the array has no reset, so program contents survive a CPU reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

    task automatic dump();
        for (int i = 0; i < DEPTH; i++)
            $display("mem[%0h] = %h", i, mem[i]);
    endtask
endmodule

module computer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_val
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_STA = 4'h5, OP_LDI = 4'h6, OP_JMP = 4'h7,
        OP_JC  = 4'h8, OP_JZ  = 4'h9, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] ir;
    logic                  c;
    logic                  z;
    logic                  halt;

    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] ram_rdata;

    opcode_t               op;
    logic [ADDR_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH:0]   sum;
    logic                  take_jump;

    logic                  load_a;
    logic                  load_b;
    logic [DATA_WIDTH-1:0] a_d;
    logic                  ram_we;

    assign op      = opcode_t'(ir[7:4]);
    assign operand = ir[ADDR_WIDTH-1:0];

    // SUB is A + ~B + 1, so the carry out reads as "no borrow".
    always_comb begin
        alu_b = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, alu_b} + {{DATA_WIDTH{1'b0}}, (op == OP_SUB)};
    end

    assign take_jump = (op == OP_JMP) || (op == OP_JC && c) || (op == OP_JZ && z);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        load_a = 1'b0;
        load_b = 1'b0;
        a_d    = sum[DATA_WIDTH-1:0];
        ram_we = 1'b0;
        if (!halt && !reset) begin
            case (state)
                T2: begin
                    if (op == OP_LDI) begin
                        load_a = 1'b1;
                        a_d    = DATA_WIDTH'(operand);
                    end
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            load_a = 1'b1;
                            a_d    = ram_rdata;
                        end
                        OP_ADD, OP_SUB: load_a = 1'b1;
                        OP_LDB:         load_b = 1'b1;
                        OP_STA:         ram_we = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (mar),
        .wdata (a),
        .rdata (ram_rdata)
    );

    data_register #(.DATA_WIDTH(DATA_WIDTH)) u_register_A (
        .clk          (clk),
        .reset        (reset),
        .load         (load_a),
        .d            (a_d),
        .latched_data (a)
    );

    data_register #(.DATA_WIDTH(DATA_WIDTH)) u_register_B (
        .clk          (clk),
        .reset        (reset),
        .load         (load_b),
        .d            (ram_rdata),
        .latched_data (b)
    );

    // Once halted, nothing advances until reset; HLT parks the sequencer in T2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= T0;
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            c       <= 1'b0;
            z       <= 1'b0;
            halt    <= 1'b0;
            out_val <= '0;
        end else if (!halt) begin
            case (state)
                T0: begin
                    mar   <= pc;
                    state <= T1;
                end
                T1: begin
                    ir    <= ram_rdata;
                    pc    <= pc + ADDR_WIDTH'(1);
                    state <= T2;
                end
                T2: begin
                    state <= T3;
                    case (op)
                        OP_LDA, OP_LDB, OP_STA: mar <= operand;
                        OP_JMP, OP_JC, OP_JZ: begin
                            if (take_jump)
                                pc <= operand;
                        end
                        OP_OUT: begin
                            out_val <= a;
`ifdef OUT_TRACE_EN
                            $display("out_val = %h", a);
`endif
                        end
                        OP_HLT: begin
                            halt  <= 1'b1;
                            state <= T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    state <= T4;
                    if (op == OP_ADD || op == OP_SUB) begin
                        c <= sum[DATA_WIDTH];
                        z <= (sum[DATA_WIDTH-1:0] == '0);
                    end
                end
                T4: state <= T0;
                default: state <= T0;
            endcase
        end
    end
endmodule

// File: tb/tb_computer.sv
// Directed bench for computer: loads small programs into RAM, runs to HLT and scores architectural state.

module tb_computer;
    logic       clk;
    logic       reset;
    logic [7:0] out_val;

    int checks;
    int failures;
    int cycles_seen;

    logic [7:0] prog [0:15];

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb [$];

    computer dut (
        .clk     (clk),
        .reset   (reset),
        .out_val (out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observe(input string tag);
        case (tag)
            "pc":     return 8'(dut.pc);
            "mar":    return 8'(dut.mar);
            "ir":     return dut.ir;
            "a":      return dut.u_register_A.latched_data;
            "b":      return dut.u_register_B.latched_data;
            "out":    return out_val;
            "c":      return 8'(dut.c);
            "z":      return 8'(dut.z);
            "halt":   return 8'(dut.halt);
            "state":  return 8'(dut.state);
            "memF":   return dut.u_ram.mem[15];
            "cycles": return 8'(cycles_seen);
            default:  return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, ".", e.tag}, observe(e.tag), e.exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++)
            prog[i] = 8'h00;
    endtask

    // Hold reset for two edges, preload RAM meanwhile, release on a falling edge.
    task automatic start_run();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++)
            dut.u_ram.mem[i] <= prog[i];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        cycles_seen = 0;
        while (dut.halt !== 1'b1 && cycles_seen < budget) begin
            @(negedge clk);
            cycles_seen++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;

        // Reset state
        clear_prog();
        start_run();
        expect_val("pc", 8'h00);   expect_val("mar", 8'h00); expect_val("ir", 8'h00);
        expect_val("a", 8'h00);    expect_val("b", 8'h00);   expect_val("out", 8'h00);
        expect_val("c", 8'h00);    expect_val("z", 8'h00);   expect_val("halt", 8'h00);
        expect_val("state", 8'h00);
        drain("reset");

        // LDB from the top word, then HLT
        clear_prog();
        prog[0] = 8'h2F; prog[1] = 8'hF0; prog[15] = 8'h11;
        start_run();
        run_to_halt(50);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd8);
        expect_val("b", 8'h11);    expect_val("a", 8'h00);   expect_val("pc", 8'h02);
        drain("ldb");

        // ADD then OUT; state must stay frozen after HLT
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h30; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'h07;
        start_run();
        run_to_halt(50);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd23);
        expect_val("out", 8'h0C);  expect_val("a", 8'h0C);   expect_val("b", 8'h07);
        expect_val("c", 8'h00);    expect_val("z", 8'h00);
        drain("add_out");
        repeat (5) @(negedge clk);
        expect_val("out", 8'h0C);  expect_val("pc", 8'h05);  expect_val("state", 8'h02);
        expect_val("halt", 8'h01);
        drain("frozen");

        // SUB to zero, JZ taken over LDI/OUT
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h40; prog[3] = 8'h96;
        prog[4] = 8'h67; prog[5] = 8'hE0; prog[6] = 8'hF0;
        prog[14] = 8'h09; prog[15] = 8'h09;
        start_run();
        run_to_halt(60);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd23);
        expect_val("z", 8'h01);    expect_val("c", 8'h01);   expect_val("a", 8'h00);
        expect_val("out", 8'h00);  expect_val("pc", 8'h07);
        drain("sub_jz");

        // STA/LDA round trip, ADD wrap FF+01, JC taken
        clear_prog();
        prog[0] = 8'h63; prog[1] = 8'h5F; prog[2] = 8'h1F; prog[3] = 8'hE0;
        prog[4] = 8'h1D; prog[5] = 8'h2C; prog[6] = 8'h30; prog[7] = 8'h8A;
        prog[8] = 8'h6E; prog[9] = 8'hF0; prog[10] = 8'hF0;
        prog[12] = 8'h01; prog[13] = 8'hFF; prog[15] = 8'hAA;
        start_run();
        run_to_halt(100);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd43);
        expect_val("memF", 8'h03); expect_val("out", 8'h03);
        expect_val("a", 8'h00);    expect_val("b", 8'h01);
        expect_val("c", 8'h01);    expect_val("z", 8'h01);   expect_val("pc", 8'h0B);
        drain("sta_wrap");
        dut.u_ram.dump();

        // JZ/JC not taken, undefined opcode, JMP to F and PC wrap to 0
        clear_prog();
        prog[0] = 8'h2C; prog[1] = 8'h61; prog[2] = 8'h30; prog[3] = 8'h9F;
        prog[4] = 8'h8F; prog[5] = 8'hA0; prog[6] = 8'hE0; prog[7] = 8'h7F;
        prog[8] = 8'hF0; prog[12] = 8'h01; prog[15] = 8'hF0;
        start_run();
        run_to_halt(100);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd43);
        expect_val("a", 8'h02);    expect_val("out", 8'h02); expect_val("b", 8'h01);
        expect_val("c", 8'h00);    expect_val("z", 8'h00);
        expect_val("pc", 8'h00);   expect_val("ir", 8'hF0);
        drain("branch_wrap");

        // Reset during T3 of STA: no write, everything cleared, rerun from 0
        clear_prog();
        prog[0] = 8'h63; prog[1] = 8'h5F; prog[2] = 8'hF0; prog[15] = 8'hAA;
        start_run();
        repeat (8) @(negedge clk);
        expect_val("state", 8'h03); expect_val("memF", 8'hAA); expect_val("a", 8'h03);
        drain("pre_abort");
        reset = 1'b1;
        @(negedge clk);
        expect_val("memF", 8'hAA); expect_val("pc", 8'h00);  expect_val("mar", 8'h00);
        expect_val("ir", 8'h00);   expect_val("a", 8'h00);   expect_val("b", 8'h00);
        expect_val("state", 8'h00); expect_val("halt", 8'h00); expect_val("out", 8'h00);
        drain("abort");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        expect_val("ir", 8'h63);   expect_val("pc", 8'h01);
        drain("restart");
        run_to_halt(50);
        expect_val("halt", 8'h01); expect_val("cycles", 8'd11);
        expect_val("memF", 8'h03); expect_val("pc", 8'h03);  expect_val("a", 8'h03);
        drain("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
